onehot_req_debounce: RTL

- Upstream front-end for the one-hot-to-binary encoder stage.
- Takes N raw, asynchronous, bouncy request lines (buttons or keypad rows) and synchronises and debounces each one.
- Turns each debounced press (rising edge) into a single clean one-hot word.
- Presents one word at a time over a valid/ready handshake, so the downstream encoder only ever sees a legal one-hot or all-zero input.

---
 rtl/onehot_req_debounce.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/onehot_req_debounce.sv
// Synchronises and debounces N raw request lines, turning each debounced press into one
// one-hot word on a valid/ready handshake. Define ONEHOT_REQ_OVF_EN to add the sticky ovf output.
module onehot_req_debounce #(
  parameter int N         = 8,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_in,
  output logic [N-1:0] onehot_out,
  output logic         valid_out,
  input  logic         ready_in,
  output logic         multi_err
`ifdef ONEHOT_REQ_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N-1:0]     s1_q, s2_q;
  logic [N-1:0]     deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [N-1:0]     rise;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     onehot_q, onehot_d;
  logic [N-1:0]     sel;
  logic [0:0]       state_q, state_d;
  logic             multi_err_q, multi_err_d;
  logic             load;

  // Highest set bit wins, matching the encoder's dominant-MSB convention.
  function automatic logic [N-1:0] msb_sel(input logic [N-1:0] v);
    logic [N-1:0] one;
    one = '0;
    one[0] = 1'b1;
    msb_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) msb_sel = one << i;
    end
  endfunction

  always_comb begin
    deb_d = deb_q;
    rise  = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = s2_q[i];
          rise[i]  = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    multi_err_d = (rise & (rise - 1'b1)) != '0;
  end

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    load     = 1'b0;
    sel      = '0;
    case (state_q)
      IDLE:    load = pending_q != '0;
      PRESENT: begin
        if (ready_in) begin
          load = pending_q != '0;
          if (!load) begin
            state_d  = IDLE;
            onehot_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      sel      = msb_sel(pending_q);
      onehot_d = sel;
      state_d  = PRESENT;
    end
    // A rise in the same cycle as its own load-clear must survive.
    pending_d = (pending_q & ~sel) | rise;
  end

  // Two-flop synchroniser, nothing between the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= req_in;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q       <= '0;
      pending_q   <= '0;
      onehot_q    <= '0;
      state_q     <= IDLE;
      multi_err_q <= 1'b0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      deb_q       <= deb_d;
      pending_q   <= pending_d;
      onehot_q    <= onehot_d;
      state_q     <= state_d;
      multi_err_q <= multi_err_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef ONEHOT_REQ_OVF_EN
  logic ovf_q, ovf_d;
  logic held_unaccepted;

  always_comb begin
    held_unaccepted = (state_q == PRESENT) && !ready_in;
    ovf_d = ovf_q | ((rise & (pending_q | (onehot_q & {N{held_unaccepted}}))) != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign onehot_out = onehot_q;
  assign valid_out  = state_q == PRESENT;
  assign multi_err  = multi_err_q;

endmodule
